calc_key_entry: RTL and testbench

CALC_KEY_ENTRY -- requirements
Module: calc_key_entry

---
 rtl/calc_key_pkg.sv | 55 +++++
 rtl/calc_key_if.sv | 27 ++
 rtl/calc_scan_class.sv | 81 ++++++++
 rtl/calc_key_entry.sv | 138 +++++++++++++
 tb/tb_calc_key_entry.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_key_pkg.sv
// Shared scan codes, FSM state encoding, operator encoding and key classes for the calculator entry block.
// CALC_KEYPAD_EN selects whether the numeric-keypad digit codes are decoded; both code tables live here.
package calc_key_pkg;

  typedef enum logic [2:0] {
    S_A1  = 3'd0,
    S_A0  = 3'd1,
    S_OP  = 3'd2,
    S_B1  = 3'd3,
    S_B0  = 3'd4,
    S_EQ  = 3'd5,
    S_RES = 3'd6,
    S_BAD = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_DIGIT = 3'd1,
    CLS_OP    = 3'd2,
    CLS_ENTER = 3'd3,
    CLS_ESC   = 3'd4,
    CLS_BKSP  = 3'd5
  } key_class_t;

  localparam int NUM_DIGITS = 10;

  // Index n holds the scan code of digit n.
  localparam logic [NUM_DIGITS-1:0][8:0] MAIN_DIGIT_CODES = {
    9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
    9'h025, 9'h026, 9'h01E, 9'h016, 9'h045
  };
  localparam logic [NUM_DIGITS-1:0][8:0] KEYPAD_DIGIT_CODES = {
    9'h07D, 9'h075, 9'h06C, 9'h074, 9'h073,
    9'h06B, 9'h07A, 9'h072, 9'h069, 9'h070
  };

  localparam logic [8:0] CODE_ADD      = 9'h079;
  localparam logic [8:0] CODE_SUB      = 9'h07B;
  localparam logic [8:0] CODE_MUL      = 9'h07C;
  localparam logic [8:0] CODE_ENTER    = 9'h05A;
  localparam logic [8:0] CODE_ENTER_E0 = 9'h15A;
  localparam logic [8:0] CODE_ESC      = 9'h076;
  localparam logic [8:0] CODE_BKSP     = 9'h066;

  function automatic logic is_enter(input logic [8:0] code);
    return (code == CODE_ENTER) || (code == CODE_ENTER_E0);
  endfunction

endpackage

// File: rtl/calc_key_if.sv
// Key-event inputs and BCD/status outputs of the calculator entry block.
// master drives keyboard events and observes the entry state; slave is the entry block itself.
interface calc_key_if;

  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [3:0]   dig_a1;
  logic [3:0]   dig_a0;
  logic [3:0]   dig_b1;
  logic [3:0]   dig_b0;
  logic [1:0]   op;
  logic [2:0]   state;
  logic         result_valid;
  logic         entry_err;

  modport master (
    output key_valid, last_change, key_down,
    input  dig_a1, dig_a0, dig_b1, dig_b0, op, state, result_valid, entry_err
  );

  modport slave (
    input  key_valid, last_change, key_down,
    output dig_a1, dig_a0, dig_b1, dig_b0, op, state, result_valid, entry_err
  );

endinterface

// File: rtl/calc_scan_class.sv
// Typematic hold-off plus scan-code classification; emits a press strobe with key class and value.
// Keypad digits are decoded only when CALC_KEYPAD_EN is defined.
module calc_scan_class
  import calc_key_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic         press,
  output key_class_t   key_class,
  output logic [3:0]   key_value
);

  logic [8:0]            held_code_reg;
  logic                  held_valid_reg;
  logic                  is_make;
  logic                  repeat_hit;
  logic [NUM_DIGITS-1:0] main_hit;
  logic [NUM_DIGITS-1:0] pad_hit;
  logic [NUM_DIGITS-1:0] digit_hit;

  assign is_make    = key_down[last_change];
  assign repeat_hit = held_valid_reg && (held_code_reg == last_change);
  assign press      = key_valid && is_make && !repeat_hit;

  // Any unsuppressed make arms the hold-off, even if the FSM later rejects the key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_code_reg  <= '0;
      held_valid_reg <= 1'b0;
    end else if (key_valid) begin
      if (is_make && !repeat_hit) begin
        held_code_reg  <= last_change;
        held_valid_reg <= 1'b1;
      end else if (!is_make && repeat_hit) begin
        held_valid_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign main_hit[gi] = (last_change == MAIN_DIGIT_CODES[gi]);
`ifdef CALC_KEYPAD_EN
    assign pad_hit[gi]  = (last_change == KEYPAD_DIGIT_CODES[gi]);
`else
    assign pad_hit[gi]  = 1'b0;
`endif
  end

  assign digit_hit = main_hit | pad_hit;

  always_comb begin
    key_class = CLS_NONE;
    key_value = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_hit[i]) begin
        key_class = CLS_DIGIT;
        key_value = 4'(i);
      end
    end
    if (last_change == CODE_ADD) begin
      key_class = CLS_OP;
      key_value = {2'b00, OP_ADD};
    end else if (last_change == CODE_SUB) begin
      key_class = CLS_OP;
      key_value = {2'b00, OP_SUB};
    end else if (last_change == CODE_MUL) begin
      key_class = CLS_OP;
      key_value = {2'b00, OP_MUL};
    end else if (is_enter(last_change)) begin
      key_class = CLS_ENTER;
    end else if (last_change == CODE_ESC) begin
      key_class = CLS_ESC;
    end else if (last_change == CODE_BKSP) begin
      key_class = CLS_BKSP;
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// Two-operand calculator key-entry FSM: collects A (2 BCD digits), an operator and B, then Enter.
// Build with CALC_KEYPAD_EN defined to accept numeric-keypad digits as well.
module calc_key_entry
  import calc_key_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  calc_key_if.slave  bus
);

  logic       press;
  key_class_t key_class;
  logic [3:0] key_value;

  state_t     state_reg, state_next;
  logic [3:0] a1_reg, a1_next;
  logic [3:0] a0_reg, a0_next;
  logic [3:0] b1_reg, b1_next;
  logic [3:0] b0_reg, b0_next;
  logic [1:0] op_reg, op_next;
  logic       rv_reg, rv_next;
  logic       err_reg, err_next;

  calc_scan_class u_scan_class (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (bus.key_valid),
    .last_change (bus.last_change),
    .key_down    (bus.key_down),
    .press       (press),
    .key_class   (key_class),
    .key_value   (key_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_A1;
      a1_reg    <= 4'd0;
      a0_reg    <= 4'd0;
      b1_reg    <= 4'd0;
      b0_reg    <= 4'd0;
      op_reg    <= 2'd0;
      rv_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a1_reg    <= a1_next;
      a0_reg    <= a0_next;
      b1_reg    <= b1_next;
      b0_reg    <= b0_next;
      op_reg    <= op_next;
      rv_reg    <= rv_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a1_next    = a1_reg;
    a0_next    = a0_reg;
    b1_next    = b1_reg;
    b0_next    = b0_reg;
    op_next    = op_reg;
    rv_next    = 1'b0;
    err_next   = 1'b0;

    if (state_reg == S_BAD) begin
      state_next = S_A1;
    end else if (press) begin
      case (key_class)
        CLS_ESC: begin
          state_next = S_A1;
          a1_next    = 4'd0;
          a0_next    = 4'd0;
          b1_next    = 4'd0;
          b0_next    = 4'd0;
          op_next    = 2'd0;
        end
        // Step back one state and forget the field that state had captured.
        CLS_BKSP: begin
          case (state_reg)
            S_A0:    begin state_next = S_A1; a1_next = 4'd0; end
            S_OP:    begin state_next = S_A0; a0_next = 4'd0; end
            S_B1:    begin state_next = S_OP; op_next = 2'd0; end
            S_B0:    begin state_next = S_B1; b1_next = 4'd0; end
            S_EQ:    begin state_next = S_B0; b0_next = 4'd0; end
            S_RES:   state_next = S_EQ;
            default: state_next = state_reg;
          endcase
        end
        CLS_DIGIT: begin
          case (state_reg)
            S_A1: begin a1_next = key_value; state_next = S_A0; end
            S_A0: begin a0_next = key_value; state_next = S_OP; end
            S_B1: begin b1_next = key_value; state_next = S_B0; end
            S_B0: begin b0_next = key_value; state_next = S_EQ; end
            S_RES: begin
              a1_next    = key_value;
              a0_next    = 4'd0;
              b1_next    = 4'd0;
              b0_next    = 4'd0;
              op_next    = 2'd0;
              state_next = S_A0;
            end
            default: err_next = 1'b1;
          endcase
        end
        CLS_OP: begin
          if (state_reg == S_OP) begin
            op_next    = key_value[1:0];
            state_next = S_B1;
          end else begin
            err_next = 1'b1;
          end
        end
        CLS_ENTER: begin
          if (state_reg == S_EQ) begin
            state_next = S_RES;
            rv_next    = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        default: err_next = 1'b1;
      endcase
    end
  end

  assign bus.dig_a1       = a1_reg;
  assign bus.dig_a0       = a0_reg;
  assign bus.dig_b1       = b1_reg;
  assign bus.dig_b0       = b0_reg;
  assign bus.op           = op_reg;
  assign bus.state        = state_reg;
  assign bus.result_valid = rv_reg;
  assign bus.entry_err    = err_reg;

endmodule

// File: tb/tb_calc_key_entry.sv
// Scoreboard bench for calc_key_entry: a token-stack reference model predicts each key event's outcome,
// a monitor compares one cycle after every strobe and checks that pulses stay low otherwise.
module tb_calc_key_entry;

  typedef struct packed {
    logic [3:0] a1;
    logic [3:0] a0;
    logic [3:0] b1;
    logic [3:0] b0;
    logic [1:0] op;
    logic [2:0] st;
    logic       rv;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  calc_key_if bus_if ();

  calc_key_entry dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int main_codes[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
  int pad_codes[10]  = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
  int op_codes[3]    = '{'h79, 'h7B, 'h7C};

  exp_t         exp_q[$];
  int           toks[$];
  bit           done = 1'b0;
  int           held = -1;
  logic [511:0] pressed = '0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           ev_idx = 0;

  // Classes: 0 none, 1 digit, 2 operator, 3 enter, 4 esc, 5 backspace.
  function automatic void classify(input int code, output int cls, output int val);
    cls = 0;
    val = 0;
    for (int i = 0; i < 10; i++) begin
      if (code == main_codes[i]) begin cls = 1; val = i; end
`ifdef CALC_KEYPAD_EN
      if (code == pad_codes[i]) begin cls = 1; val = i; end
`endif
    end
    for (int i = 0; i < 3; i++)
      if (code == op_codes[i]) begin cls = 2; val = i; end
    if (code == 'h5A || code == 'h15A) cls = 3;
    if (code == 'h76) cls = 4;
    if (code == 'h66) cls = 5;
  endfunction

  // Entry is a stack of tokens A1,A0,OP,B1,B0; the state is its depth, or 6 once Enter is taken.
  function automatic exp_t model_view(input bit rv, input bit err);
    exp_t e;
    e.a1  = (toks.size() > 0) ? 4'(toks[0]) : 4'd0;
    e.a0  = (toks.size() > 1) ? 4'(toks[1]) : 4'd0;
    e.op  = (toks.size() > 2) ? 2'(toks[2]) : 2'd0;
    e.b1  = (toks.size() > 3) ? 4'(toks[3]) : 4'd0;
    e.b0  = (toks.size() > 4) ? 4'(toks[4]) : 4'd0;
    e.st  = done ? 3'd6 : 3'(toks.size());
    e.rv  = rv;
    e.err = err;
    return e;
  endfunction

  task automatic model_event(input int code, input bit make);
    int cls;
    int val;
    bit rv;
    bit err;
    rv  = 1'b0;
    err = 1'b0;
    if (make) begin
      if (code != held) begin
        held = code;
        classify(code, cls, val);
        case (cls)
          4: begin toks.delete(); done = 1'b0; end
          5: begin
            if (done) done = 1'b0;
            else if (toks.size() > 0) void'(toks.pop_back());
          end
          1: begin
            if (done) begin
              toks.delete();
              toks.push_back(val);
              done = 1'b0;
            end else if (toks.size() inside {0, 1, 3, 4}) begin
              toks.push_back(val);
            end else begin
              err = 1'b1;
            end
          end
          2: if (!done && toks.size() == 2) toks.push_back(val); else err = 1'b1;
          3: if (!done && toks.size() == 5) begin done = 1'b1; rv = 1'b1; end else err = 1'b1;
          default: err = 1'b1;
        endcase
      end
    end else if (code == held) begin
      held = -1;
    end
    exp_q.push_back(model_view(rv, err));
  endtask

  task automatic send(input int code, input bit make);
    pressed[code] = make;
    model_event(code, make);
    @(posedge clk);
    #1;
    bus_if.last_change = code[8:0];
    bus_if.key_down    = pressed;
    bus_if.key_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.key_valid   = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t dut_view();
    return {bus_if.dig_a1, bus_if.dig_a0, bus_if.dig_b1, bus_if.dig_b0,
            bus_if.op, bus_if.state, bus_if.result_valid, bus_if.entry_err};
  endfunction

  initial begin : monitor
    bit   ev;
    exp_t act;
    exp_t e;
    forever begin
      @(posedge clk);
      ev = bus_if.key_valid;
      @(negedge clk);
      act = dut_view();
      n_checks++;
      if (ev) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL evt%0d no_expectation: got st=%0d", ev_idx, act.st);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL evt%0d outputs: got a=%0d%0d b=%0d%0d op=%0d st=%0d rv=%0d err=%0d, expected a=%0d%0d b=%0d%0d op=%0d st=%0d rv=%0d err=%0d",
                     ev_idx, act.a1, act.a0, act.b1, act.b0, act.op, act.st, act.rv, act.err,
                     e.a1, e.a0, e.b1, e.b0, e.op, e.st, e.rv, e.err);
          end
        end
        ev_idx++;
      end else if (act.rv !== 1'b0 || act.err !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_pulse after evt%0d: got rv=%0d err=%0d, expected 0 0", ev_idx, act.rv, act.err);
      end
    end
  end

  initial begin : stimulus
    int r;
    int code;
    bit make;
    int last_code;
    bus_if.key_valid   = 1'b0;
    bus_if.last_change = '0;
    bus_if.key_down    = '0;
    #2 reset = 1'b0;
    #2;
    check("reset_state", int'(bus_if.state), 0);
    check("reset_digits", int'({bus_if.dig_a1, bus_if.dig_a0, bus_if.dig_b1, bus_if.dig_b0}), 0);
    check("reset_pulses", int'({bus_if.result_valid, bus_if.entry_err}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 12 op 34 then Enter
    send('h16, 1); send('h1E, 1); send('h79, 1); send('h26, 1); send('h25, 1); send('h5A, 1);
    check("seq_a", int'({bus_if.dig_a1, bus_if.dig_a0}), 'h12);
    check("seq_b", int'({bus_if.dig_b1, bus_if.dig_b0}), 'h34);
    check("seq_op", int'(bus_if.op), 0);
    check("seq_state", int'(bus_if.state), 6);
    check("seq_rv", int'(bus_if.result_valid), 1);

    // Typematic repeat suppression
    send('h76, 1);
    send('h16, 1); send('h16, 1); send('h16, 1);
    check("rpt_a1", int'(bus_if.dig_a1), 1);
    check("rpt_state", int'(bus_if.state), 1);
    send('h16, 0); send('h16, 1);
    check("rpt_a0", int'(bus_if.dig_a0), 1);
    check("rpt_state2", int'(bus_if.state), 2);

    // Digit while waiting for an operator
    send('h16, 0); send('h16, 1);
    check("wrong_class_err", int'(bus_if.entry_err), 1);
    check("wrong_class_state", int'(bus_if.state), 2);
    check("wrong_class_a", int'({bus_if.dig_a1, bus_if.dig_a0}), 'h11);

    // 98 * 7, Backspace, Esc
    send('h76, 1);
    send('h46, 1); send('h3E, 1); send('h7C, 1); send('h3D, 1);
    check("bk_pre_b1", int'(bus_if.dig_b1), 7);
    send('h66, 1);
    check("bk_state", int'(bus_if.state), 3);
    check("bk_b1", int'(bus_if.dig_b1), 0);
    check("bk_op", int'(bus_if.op), 2);
    send('h76, 1);
    check("esc_state", int'(bus_if.state), 0);
    check("esc_fields", int'({bus_if.dig_a1, bus_if.dig_a0, bus_if.dig_b1, bus_if.dig_b0, bus_if.op}), 0);
    check("esc_err", int'(bus_if.entry_err), 0);

    // Keypad digit 1
    send('h69, 1);
`ifdef CALC_KEYPAD_EN
    check("keypad_a1", int'(bus_if.dig_a1), 1);
`else
    check("keypad_err", int'(bus_if.entry_err), 1);
    check("keypad_state", int'(bus_if.state), 0);
`endif

    // Asynchronous reset in S_B0, then the held key must be accepted again
    send('h76, 1);
    send('h16, 1); send('h1E, 1); send('h79, 1); send('h26, 1);
    check("pre_reset_state", int'(bus_if.state), 4);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_state", int'(bus_if.state), 0);
    check("async_fields", int'({bus_if.dig_a1, bus_if.dig_a0, bus_if.dig_b1, bus_if.dig_b0, bus_if.op}), 0);
    toks.delete();
    done = 1'b0;
    held = -1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    send('h26, 1);
    check("post_reset_a1", int'(bus_if.dig_a1), 3);
    check("post_reset_state", int'(bus_if.state), 1);

    // Randomized traffic
    last_code = 'h16;
    for (int n = 0; n < 600; n++) begin
      r    = $urandom_range(0, 99);
      make = 1'b1;
      if (r < 40)      code = main_codes[$urandom_range(0, 9)];
      else if (r < 50) code = op_codes[$urandom_range(0, 2)];
      else if (r < 57) code = ($urandom_range(0, 1) == 1) ? 'h5A : 'h15A;
      else if (r < 60) code = 'h76;
      else if (r < 68) code = 'h66;
      else if (r < 73) code = pad_codes[$urandom_range(0, 9)];
      else if (r < 78) code = $urandom_range(0, 511);
      else if (r < 86) code = last_code;
      else begin
        make = 1'b0;
        code = ($urandom_range(0, 1) == 1) ? last_code : main_codes[$urandom_range(0, 9)];
      end
      if (make) last_code = code;
      send(code, make);
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
